// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Fetch stage between the ProgramCounter, instruction memory and decode.
//   It reads the current PC, issues one instruction-memory request at a time
//   over a req/ack handshake, and buffers the returned words with their PCs in
//   a small FIFO for decode. It also computes the next PC (Address), which the
//   ProgramCounter loads every cycle.
//
// Parameters:
//   DEPTH   instruction FIFO entries (2..4)
//   PC_INC  byte increment applied to the PC after each accepted fetch
//
// Optional feature (compile-time macro IFU_ALIGN_CHECK_EN):
//   When defined, an AlignFault output is added. A misaligned PC seen in IDLE
//   raises a sticky fault that stops all further fetching and ignores branches.
//   When undefined, the low PC bits pass to IMemAddr unchanged.
//
// Ports:
//   Clk           in   1   clock, rising edge
//   Reset         in   1   asynchronous reset, active-low
//   PCResult      in   32  current PC from ProgramCounter
//   Address       out  32  next PC to ProgramCounter (combinational)
//   BranchTaken   in   1   redirect request, single-cycle pulse
//   BranchTarget  in   32  redirect PC, valid with BranchTaken
//   IMemReq       out  1   fetch request to instruction memory
//   IMemAddr      out  32  fetch address, stable while IMemReq=1
//   IMemAck       in   1   memory completes request; IMemRdata valid same cycle
//   IMemRdata     in   32  fetched instruction word
//   InstrValid    out  1   FIFO head valid
//   Instr         out  32  FIFO head instruction
//   InstrPC       out  32  PC of FIFO head instruction
//   InstrReady    in   1   decode accepts head when InstrValid & InstrReady
//   AlignFault    out  1   sticky misaligned-PC fault (IFU_ALIGN_CHECK_EN only)
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int          DEPTH  = 2,
  parameter logic [31:0] PC_INC = 32'd4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCResult,
  output logic [31:0] Address,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemRdata,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  input  logic        InstrReady
`ifdef IFU_ALIGN_CHECK_EN
  ,
  output logic        AlignFault
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // nothing outstanding
    ST_WAIT = 2'd1,  // request outstanding, result kept
    ST_DROP = 2'd2   // request outstanding, result discarded
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_req;
  logic               w_req_nxt;
  logic [31:0]        r_addr;
  logic [31:0]        w_addr_nxt;
  logic               w_push;
  logic               w_pop;
  logic               w_branch;
  logic               w_misaligned;
  logic               w_fault_set;
  logic               r_align_fault;

  logic [31:0]        r_fifo_instr [DEPTH];
  logic [31:0]        r_fifo_pc    [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;

  // Advance a FIFO pointer, wrapping at DEPTH (DEPTH need not be a power of 2).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // In the default build the misalignment detector is tied off, so the fault
  // register stays at zero and is trimmed away.
`ifdef IFU_ALIGN_CHECK_EN
  assign w_misaligned = (PCResult[1:0] != 2'b00);
  assign AlignFault   = r_align_fault;
`else
  assign w_misaligned = 1'b0;
`endif

  // A latched fault freezes the unit, including ignoring redirects.
  assign w_branch = BranchTaken & ~r_align_fault;
  assign w_pop    = InstrValid & InstrReady;

  // Next-state, request and FIFO-push decode for the fetch FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_push      = 1'b0;
    w_fault_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_branch) begin
          w_state_nxt = ST_IDLE;   // PC is being redirected; fetch next cycle
        end else if (r_align_fault) begin
          w_state_nxt = ST_IDLE;
        end else if (w_misaligned) begin
          w_fault_set = 1'b1;
        end else if (r_count < CNT_W'(DEPTH)) begin
          w_state_nxt = ST_WAIT;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = PCResult;
        end else begin
          w_state_nxt = ST_IDLE;   // FIFO full, hold off
        end
      end
      ST_WAIT: begin
        if (IMemAck) begin
          // An ack coinciding with a redirect belongs to the old path.
          w_push      = ~w_branch;
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end else if (w_branch) begin
          w_state_nxt = ST_DROP;   // request must still complete, then be dropped
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (IMemAck) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DROP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_req_nxt   = 1'b0;
        w_addr_nxt  = 32'd0;
      end
    endcase
  end

  // Fetch FSM state, memory request/address and sticky alignment fault.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state       <= ST_IDLE;
      r_req         <= 1'b0;
      r_addr        <= 32'd0;
      r_align_fault <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_req         <= w_req_nxt;
      r_addr        <= w_addr_nxt;
      r_align_fault <= r_align_fault | w_fault_set;
    end
  end

  // Next PC: redirect wins, then post-increment on an accepted ack, else hold.
  always_comb begin
    Address = PCResult;
    if (w_branch) begin
      Address = BranchTarget;
    end else if ((r_state == ST_WAIT) && IMemAck) begin
      Address = r_addr + PC_INC;
    end else begin
      Address = PCResult;
    end
  end

  // Instruction FIFO storage, pointers and occupancy; a redirect flushes it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_instr[i] <= 32'd0;
        r_fifo_pc[i]    <= 32'd0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_branch) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_instr[r_wr_ptr] <= IMemRdata;
        r_fifo_pc[r_wr_ptr]    <= r_addr;
        r_wr_ptr               <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign IMemReq    = r_req;
  assign IMemAddr   = r_addr;
  assign InstrValid = (r_count != '0);
  assign Instr      = r_fifo_instr[r_rd_ptr];
  assign InstrPC    = r_fifo_pc[r_rd_ptr];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed bench for instruction_fetch_unit. The bench models the
// ProgramCounter (loads Address every cycle, reset to 0) and an instruction
// memory whose word at address A is A ^ 32'hDEAD0000. Inputs change 1 time
// unit after a rising edge; outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_r;
  logic        pc_force = 1'b0;
  logic [31:0] pc_force_val = 32'd0;
  logic [31:0] pc_result;
  logic [31:0] address;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
  logic        align_fault;
`endif

  int checks   = 0;
  int failures = 0;

  instruction_fetch_unit #(.DEPTH(2), .PC_INC(32'd4)) dut (
    .Clk          (clk),
    .Reset        (rst_n),
    .PCResult     (pc_result),
    .Address      (address),
    .BranchTaken  (branch_taken),
    .BranchTarget (branch_target),
    .IMemReq      (imem_req),
    .IMemAddr     (imem_addr),
    .IMemAck      (imem_ack),
    .IMemRdata    (imem_rdata),
    .InstrValid   (instr_valid),
    .Instr        (instr),
    .InstrPC      (instr_pc),
    .InstrReady   (instr_ready)
`ifdef IFU_ALIGN_CHECK_EN
    ,
    .AlignFault   (align_fault)
`endif
  );

  always #5 clk = ~clk;

  // ProgramCounter model: loads Address every cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_r <= 32'd0;
    else        pc_r <= address;
  end

  assign pc_result  = pc_force ? pc_force_val : pc_r;
  assign imem_rdata = imem_addr ^ 32'hDEAD0000;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ack, input logic ready);
    rst_n         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    pc_force      = 1'b0;
    imem_ack      = 1'b0;
    instr_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    imem_ack    = ack;
    instr_ready = ready;
    rst_n       = 1'b1;
  endtask

  task automatic test_reset;
    rst_n        = 1'b0;
    imem_ack     = 1'b1;
    instr_ready  = 1'b1;
    branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0h exp=0", imem_req); end
    checks++; if (imem_addr !== 32'd0) begin failures++; $display("FAIL rst_addr got=%0h exp=0", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", instr_valid); end
    checks++; if (instr !== 32'd0) begin failures++; $display("FAIL rst_instr got=%0h exp=0", instr); end
    checks++; if (instr_pc !== 32'd0) begin failures++; $display("FAIL rst_instr_pc got=%0h exp=0", instr_pc); end
    checks++; if (address !== 32'd0) begin failures++; $display("FAIL rst_address got=%0h exp=0", address); end
`ifdef IFU_ALIGN_CHECK_EN
    checks++; if (align_fault !== 1'b0) begin failures++; $display("FAIL rst_fault got=%0h exp=0", align_fault); end
`endif
  endtask

  task automatic test_stream;
    logic [31:0] a;
    do_reset(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      a = 32'd4 * k;
      tick();  // issue edge
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL stream_req k=%0d got=%0h exp=1", k, imem_req); end
      checks++; if (imem_addr !== a) begin failures++; $display("FAIL stream_addr k=%0d got=%0h exp=%0h", k, imem_addr, a); end
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_valid0 k=%0d got=%0h exp=0", k, instr_valid); end
      checks++; if (address !== a + 32'd4) begin failures++; $display("FAIL stream_next_pc k=%0d got=%0h exp=%0h", k, address, a + 32'd4); end
      tick();  // ack edge: word pushed
      checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL stream_valid1 k=%0d got=%0h exp=1", k, instr_valid); end
      checks++; if (instr !== (32'hDEAD0000 + a)) begin failures++; $display("FAIL stream_instr k=%0d got=%0h exp=%0h", k, instr, 32'hDEAD0000 + a); end
      checks++; if (instr_pc !== a) begin failures++; $display("FAIL stream_instr_pc k=%0d got=%0h exp=%0h", k, instr_pc, a); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stream_req_low k=%0d got=%0h exp=0", k, imem_req); end
      checks++; if (address !== a + 32'd4) begin failures++; $display("FAIL stream_hold_pc k=%0d got=%0h exp=%0h", k, address, a + 32'd4); end
    end
  endtask

  task automatic test_backpressure;
    int req_cycles;
    req_cycles = 0;
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (imem_req === 1'b1) req_cycles++;
    end
    checks++; if (req_cycles !== 2) begin failures++; $display("FAIL bp_ack_count got=%0d exp=2", req_cycles); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_idle got=%0h exp=0", imem_req); end
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%0h exp=1", instr_valid); end
    checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL bp_head0_pc got=%0h exp=0", instr_pc); end
    checks++; if (instr !== 32'hDEAD0000) begin failures++; $display("FAIL bp_head0_instr got=%0h exp=dead0000", instr); end
    checks++; if (address !== 32'h8) begin failures++; $display("FAIL bp_address got=%0h exp=8", address); end
    instr_ready = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL bp_valid2 got=%0h exp=1", instr_valid); end
    checks++; if (instr_pc !== 32'h4) begin failures++; $display("FAIL bp_head1_pc got=%0h exp=4", instr_pc); end
    checks++; if (instr !== 32'hDEAD0004) begin failures++; $display("FAIL bp_head1_instr got=%0h exp=dead0004", instr); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_no_issue_full got=%0h exp=0", imem_req); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%0h exp=0", instr_valid); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL bp_reissue_req got=%0h exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL bp_reissue_addr got=%0h exp=8", imem_addr); end
  endtask

  task automatic test_branch_drop;
    do_reset(1'b0, 1'b1);
    tick();  // issue 0x0
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin failures++; $display("FAIL bd_issue0 got=%0h/%0h exp=1/0", imem_req, imem_addr); end
    imem_ack = 1'b1;
    tick();  // push 0x0
    imem_ack = 1'b0;
    tick();  // pop 0x0, issue 0x4
    checks++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin failures++; $display("FAIL bd_issue4 got=%0h/%0h exp=1/4", imem_req, imem_addr); end
    imem_ack    = 1'b1;
    instr_ready = 1'b0;
    tick();  // push 0x4
    imem_ack = 1'b0;
    tick();  // issue 0x8
    checks++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin failures++; $display("FAIL bd_issue8 got=%0h/%0h exp=1/8", imem_req, imem_addr); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin failures++; $display("FAIL bd_prefill got=%0h/%0h exp=1/4", instr_valid, instr_pc); end
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    #1;
    checks++; if (address !== 32'h100) begin failures++; $display("FAIL bd_redirect got=%0h exp=100", address); end
    tick();
    branch_taken = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL bd_flush got=%0h exp=0", instr_valid); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL bd_hold i=%0d got=%0h/%0h exp=1/8", i, imem_req, imem_addr); end
      if (i < 2) tick();
    end
    imem_ack = 1'b1;
    #1;
    checks++; if (address !== 32'h100) begin failures++; $display("FAIL bd_drop_address got=%0h exp=100", address); end
    tick();  // dropped ack
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bd_req_released got=%0h exp=0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL bd_nothing_pushed got=%0h exp=0", instr_valid); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL bd_new_fetch got=%0h/%0h exp=1/100", imem_req, imem_addr); end
  endtask

  task automatic test_branch_ack;
    do_reset(1'b0, 1'b0);
    tick();  // issue 0x0
    imem_ack      = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    #1;
    checks++; if (address !== 32'h200) begin failures++; $display("FAIL ba_address got=%0h exp=200", address); end
    tick();
    imem_ack     = 1'b0;
    branch_taken = 1'b0;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL ba_req got=%0h exp=0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL ba_no_push got=%0h exp=0", instr_valid); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL ba_idle_issue got=%0h/%0h exp=1/200", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid;
    do_reset(1'b0, 1'b0);
    tick();  // issue 0x0
    imem_ack = 1'b1;
    tick();  // push 0x0
    imem_ack = 1'b0;
    tick();  // issue 0x4
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b1) begin failures++; $display("FAIL rm_pre got=%0h/%0h/%0h exp=1/4/1", imem_req, imem_addr, instr_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rm_req got=%0h exp=0", imem_req); end
    checks++; if (imem_addr !== 32'd0) begin failures++; $display("FAIL rm_addr got=%0h exp=0", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%0h exp=0", instr_valid); end
    checks++; if (instr !== 32'd0 || instr_pc !== 32'd0) begin failures++; $display("FAIL rm_head got=%0h/%0h exp=0/0", instr, instr_pc); end
    checks++; if (address !== 32'd0) begin failures++; $display("FAIL rm_address got=%0h exp=0", address); end
    rst_n = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin failures++; $display("FAIL rm_restart got=%0h/%0h exp=1/0", imem_req, imem_addr); end
  endtask

`ifdef IFU_ALIGN_CHECK_EN
  task automatic test_align;
    do_reset(1'b0, 1'b0);
    pc_force     = 1'b1;
    pc_force_val = 32'h102;
    tick();
    checks++; if (align_fault !== 1'b1) begin failures++; $display("FAIL al_fault got=%0h exp=1", align_fault); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL al_req got=%0h exp=0", imem_req); end
    checks++; if (address !== 32'h102) begin failures++; $display("FAIL al_address got=%0h exp=102", address); end
    branch_taken  = 1'b1;
    branch_target = 32'h300;
    #1;
    checks++; if (address !== 32'h102) begin failures++; $display("FAIL al_branch_ignored got=%0h exp=102", address); end
    tick();
    branch_taken = 1'b0;
    tick();
    checks++; if (align_fault !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL al_sticky got=%0h/%0h exp=1/0", align_fault, imem_req); end
    pc_force = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_branch_drop();
    test_branch_ack();
    test_reset_mid();
`ifdef IFU_ALIGN_CHECK_EN
    test_align();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
